cw_decoder_top: RTL and testbench

- Inverse of the constant-weight encoder. Accepts a stream of sorted 10-bit codeword positions (the weight-t word's one-positions) and rebuilds the binary message, emitting it as a byte stream.
- Run-length decoding: each gap between consecutive positions becomes a unary quotient plus a fixed-width U-bit remainder.
- Sits between the codeword channel and the message sink, mirroring the encoder's byte-in / position-out interface.

---
 rtl/cw_pkg.sv | 25 ++
 rtl/cw_decoder_if.sv | 21 ++
 rtl/cw_byte_packer.sv | 59 +++++
 rtl/cw_decoder_top.sv | 122 ++++++++++++
 tb/tb_cw_decoder_top.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cw_pkg.sv
// Shared constants, derived widths and FSM encoding for the constant-weight decoder.
// Optional build macro CW_ORDER_CHECK_EN is consumed by cw_decoder_top.
package cw_pkg;

    localparam int POS_W     = 10;
    localparam int U         = 3;
    localparam int MSG_BYTES = 40;

    localparam int Q_W    = POS_W - U;
    localparam int BCNT_W = $clog2(MSG_BYTES + 1);
    localparam int RC_W   = (U > 1) ? $clog2(U) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_CW = 3'd1;
    localparam logic [2:0] S_EMIT_Q  = 3'd2;
    localparam logic [2:0] S_EMIT_Z  = 3'd3;
    localparam logic [2:0] S_EMIT_R  = 3'd4;
    localparam logic [2:0] S_FLUSH   = 3'd5;

    // A partial byte keeps its n newest bits in the LSBs; move them to the top, zero below.
    function automatic logic [7:0] pad_byte(input logic [7:0] sr, input logic [2:0] n);
        return sr << (4'd8 - {1'b0, n});
    endfunction

endpackage

// File: rtl/cw_decoder_if.sv
// Codeword-in / message-byte-out channel of the constant-weight decoder.
interface cw_decoder_if;

    logic [cw_pkg::POS_W-1:0] cw_in;
    logic                     cw_wr_en;
    logic                     cw_last;
    logic                     cw_rdy;
    logic [7:0]               msg_byte;
    logic                     msg_vld;

    modport master (
        output cw_in, cw_wr_en, cw_last,
        input  cw_rdy, msg_byte, msg_vld
    );

    modport slave (
        input  cw_in, cw_wr_en, cw_last,
        output cw_rdy, msg_byte, msg_vld
    );

endinterface

// File: rtl/cw_byte_packer.sv
// Serial-to-byte packer: MSB-first shift register, byte strobe, zero-padded flush, byte count.
module cw_byte_packer
    import cw_pkg::*;
(
    input  logic       clk,
    input  logic       rst_b,
    input  logic       clear,
    input  logic       bit_vld,
    input  logic       bit_in,
    input  logic       flush,
    output logic [7:0] msg_byte,
    output logic       msg_vld,
    output logic       full
);

    logic [7:0]        shreg;
    logic [2:0]        bit_cnt;
    logic [BCNT_W-1:0] byte_cnt;
    logic [7:0]        next_sr;

    // NOTE: every signal written in always_comb gets a default first, so no latch can form.
    always_comb begin
        next_sr = {shreg[6:0], bit_in};
    end

    assign full = (byte_cnt == BCNT_W'(MSG_BYTES));

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            msg_byte <= '0;
            msg_vld  <= 1'b0;
        end else begin
            msg_vld <= 1'b0;
            if (clear) begin
                shreg    <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (bit_vld && !full) begin
                shreg   <= next_sr;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    msg_byte <= next_sr;
                    msg_vld  <= 1'b1;
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end else if (flush && !full && bit_cnt != 3'd0) begin
                msg_byte <= pad_byte(shreg, bit_cnt);
                msg_vld  <= 1'b1;
                byte_cnt <= byte_cnt + 1'b1;
                bit_cnt  <= '0;
            end
        end
    end

endmodule

// File: rtl/cw_decoder_top.sv
// Constant-weight decoder: sorted positions -> run-length gaps -> unary/U-bit bits -> bytes.
// Define CW_ORDER_CHECK_EN to abort with err on a non-increasing position.
module cw_decoder_top
    import cw_pkg::*;
(
    input  logic         clk,
    input  logic         rst_b,
    input  logic         start,
    cw_decoder_if.slave  cw,
    output logic         msg_done,
    output logic         err
);

    logic [2:0]       state;
    logic [POS_W-1:0] base;
    logic [Q_W-1:0]   q_cnt;
    logic [U-1:0]     r_reg;
    logic [RC_W-1:0]  r_cnt;
    logic             last_q;

    logic [POS_W-1:0] delta;
    logic             accept;
    logic             order_err;
    logic             bit_vld;
    logic             bit_in;
    logic             full;

    assign delta     = cw.cw_in - base;
    assign cw.cw_rdy = (state == S_WAIT_CW) && !full;
    assign accept    = cw.cw_wr_en && cw.cw_rdy;
    assign bit_vld   = (state == S_EMIT_Q) || (state == S_EMIT_Z) || (state == S_EMIT_R);

`ifdef CW_ORDER_CHECK_EN
    assign order_err = (cw.cw_in < base);
`else
    assign order_err = 1'b0;
`endif

    always_comb begin
        bit_in = 1'b0;
        case (state)
            S_EMIT_Q: bit_in = 1'b1;
            S_EMIT_R: bit_in = r_reg[U-1];
            default:  bit_in = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= S_IDLE;
            base     <= '0;
            q_cnt    <= '0;
            r_reg    <= '0;
            r_cnt    <= '0;
            last_q   <= 1'b0;
            msg_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            msg_done <= 1'b0;
            if (start) begin
                state <= S_WAIT_CW;
                base  <= '0;
                err   <= 1'b0;
            end else if (state != S_IDLE && full) begin
                // Byte limit reached: whatever is left of the current symbol is dropped.
                state    <= S_IDLE;
                msg_done <= 1'b1;
            end else begin
                case (state)
                    S_WAIT_CW: begin
                        if (accept) begin
                            if (order_err) begin
                                err      <= 1'b1;
                                msg_done <= 1'b1;
                                state    <= S_IDLE;
                            end else begin
                                base   <= cw.cw_in + 1'b1;
                                q_cnt  <= delta[POS_W-1:U];
                                r_reg  <= delta[U-1:0];
                                last_q <= cw.cw_last;
                                state  <= (delta[POS_W-1:U] == '0) ? S_EMIT_Z : S_EMIT_Q;
                            end
                        end
                    end
                    S_EMIT_Q: begin
                        q_cnt <= q_cnt - 1'b1;
                        if (q_cnt == Q_W'(1)) state <= S_EMIT_Z;
                    end
                    S_EMIT_Z: begin
                        r_cnt <= RC_W'(U - 1);
                        state <= S_EMIT_R;
                    end
                    S_EMIT_R: begin
                        r_reg <= r_reg << 1;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == '0) state <= last_q ? S_FLUSH : S_WAIT_CW;
                    end
                    S_FLUSH: begin
                        // Codeword ended before the message filled: short message.
                        err      <= 1'b1;
                        msg_done <= 1'b1;
                        state    <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    cw_byte_packer u_packer (
        .clk      (clk),
        .rst_b    (rst_b),
        .clear    (start),
        .bit_vld  (bit_vld && !start),
        .bit_in   (bit_in),
        .flush    ((state == S_FLUSH) && !start),
        .msg_byte (cw.msg_byte),
        .msg_vld  (cw.msg_vld),
        .full     (full)
    );

endmodule

// File: tb/tb_cw_decoder_top.sv
// Scoreboard bench for cw_decoder_top: directed position streams, queued expected bytes/done.
module tb_cw_decoder_top;
    import cw_pkg::*;

    localparam int MSG_BITS = MSG_BYTES * 8;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    logic start = 1'b0;
    logic msg_done;
    logic err;

    cw_decoder_if cw();

    cw_decoder_top dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .start    (start),
        .cw       (cw),
        .msg_done (msg_done),
        .err      (err)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_bytes[$];
    logic       exp_done[$];
    int         stim[$];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT strobe against the head of the expectation queues.
    always @(negedge clk) begin
        if (rst_b) begin
            if (cw.msg_vld) begin
                if (exp_bytes.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_msg_vld got %02h expected none", cw.msg_byte);
                end else begin
                    check("msg_byte", 32'(cw.msg_byte), 32'(exp_bytes.pop_front()));
                end
            end
            if (msg_done) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_msg_done got 1 expected 0");
                end else begin
                    check("done_err", 32'(err), 32'(exp_done.pop_front()));
                    check("bytes_left_at_done", exp_bytes.size(), 0);
                end
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_pos(input int p, input logic last, output int waited);
        waited = 0;
        @(negedge clk);
        cw.cw_in    = POS_W'(p);
        cw.cw_wr_en = 1'b1;
        cw.cw_last  = last;
        while (!cw.cw_rdy && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!cw.cw_rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got cw_rdy=0 expected 1 for pos %0d", p);
        end else begin
            @(posedge clk);
        end
        #1;
        cw.cw_wr_en = 1'b0;
        cw.cw_last  = 1'b0;
    endtask

    task automatic send_stim();
        int w;
        foreach (stim[i]) send_pos(stim[i], (i == stim.size() - 1), w);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_done.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", exp_done.size(), 0);
        check("bytes_drained", exp_bytes.size(), 0);
    endtask

    // Reference decoder: positions -> bit stream -> expected bytes and done/err outcome.
    task automatic model_expect();
        logic bits[$];
        int   base    = 0;
        bit   stopped = 0;
        int   nbytes;
        int   v;
        foreach (stim[i]) begin
            int p;
            int d;
            p = stim[i];
            if (bits.size() >= MSG_BITS) break;
`ifdef CW_ORDER_CHECK_EN
            if (p < base) begin
                stopped = 1;
                break;
            end
`endif
            d    = (p - base) & ((1 << POS_W) - 1);
            base = (p + 1) & ((1 << POS_W) - 1);
            for (int k = 0; k < (d >> U); k++) bits.push_back(1'b1);
            bits.push_back(1'b0);
            for (int b = U - 1; b >= 0; b--) bits.push_back(1'((d >> b) & 1));
        end
        if (bits.size() >= MSG_BITS) begin
            nbytes = MSG_BYTES;
        end else begin
            nbytes = bits.size() / 8;
            if (!stopped && (bits.size() % 8) != 0) nbytes++;
        end
        for (int j = 0; j < nbytes; j++) begin
            v = 0;
            for (int k = 0; k < 8; k++)
                v = (v << 1) | ((j * 8 + k < bits.size()) ? int'(bits[j * 8 + k]) : 0);
            exp_bytes.push_back(8'(v));
        end
        exp_done.push_back(bits.size() < MSG_BITS);
    endtask

    task automatic run_basic();
        int w;
        exp_bytes.push_back(8'h5A);
        exp_bytes.push_back(8'h00);
        exp_done.push_back(1'b1);
        send_pos(5, 1'b0, w);
        check("rdy_wait_first", w, 0);
        send_pos(18, 1'b0, w);
        check("rdy_drop_pos5", w, 4);
        send_pos(19, 1'b1, w);
        check("rdy_drop_pos18", w, 5);
        drain();
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] msg[MSG_BYTES];
        logic       mbits[$];
        int         idx;
        int         q;
        int         r;
        int         base;
        int         w;

        cw.cw_in    = '0;
        cw.cw_wr_en = 1'b0;
        cw.cw_last  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_cw_rdy", 32'(cw.cw_rdy), 0);
        check("rst_msg_byte", 32'(cw.msg_byte), 0);
        check("rst_msg_vld", 32'(cw.msg_vld), 0);
        check("rst_msg_done", 32'(msg_done), 0);
        check("rst_err", 32'(err), 0);
        rst_b = 1'b1;
        @(negedge clk);
        check("idle_cw_rdy", 32'(cw.cw_rdy), 0);

        do_start();
        run_basic();

        do_start();
        exp_bytes.push_back(8'h00);
        exp_done.push_back(1'b1);
        send_pos(0, 1'b1, w);
        drain();

        do_start();
        repeat (15) exp_bytes.push_back(8'hFF);
        exp_bytes.push_back(8'hFE);
        exp_bytes.push_back(8'hE0);
        exp_done.push_back(1'b1);
        send_pos(1023, 1'b1, w);
        drain();

        do_start();
        stim = '{1023, 1023, 1023};
        model_expect();
        send_stim();
        drain();
        @(negedge clk);
        check("limit_cw_rdy", 32'(cw.cw_rdy), 0);

        do_start();
`ifndef CW_ORDER_CHECK_EN
        exp_bytes.push_back(8'hD3);
        repeat (15) exp_bytes.push_back(8'hFF);
        exp_bytes.push_back(8'hF5);
`endif
        exp_done.push_back(1'b1);
        send_pos(20, 1'b0, w);
        send_pos(10, 1'b1, w);
        drain();

        // Loopback: run-length encode a known message here, decode it in the DUT.
        for (int i = 0; i < MSG_BYTES; i++) msg[i] = 8'h40;
        for (int i = 0; i < MSG_BYTES; i++)
            for (int b = 7; b >= 0; b--) mbits.push_back(msg[i][b]);
        stim.delete();
        idx  = 0;
        base = 0;
        while (idx < MSG_BITS) begin
            q = 0;
            while (mbits[idx]) begin
                q++;
                idx++;
            end
            idx++;
            r = 0;
            for (int b = 0; b < U; b++) begin
                r = (r << 1) | int'(mbits[idx]);
                idx++;
            end
            stim.push_back(base + (q << U) + r);
            base = base + (q << U) + r + 1;
        end
        do_start();
        for (int i = 0; i < MSG_BYTES; i++) exp_bytes.push_back(msg[i]);
        exp_done.push_back(1'b0);
        send_stim();
        drain();

        do_start();
        send_pos(1023, 1'b0, w);
        repeat (5) @(negedge clk);
        rst_b = 1'b0;
        #1;
        check("midrst_cw_rdy", 32'(cw.cw_rdy), 0);
        check("midrst_msg_byte", 32'(cw.msg_byte), 0);
        check("midrst_msg_vld", 32'(cw.msg_vld), 0);
        check("midrst_msg_done", 32'(msg_done), 0);
        check("midrst_err", 32'(err), 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("midrst_idle_rdy", 32'(cw.cw_rdy), 0);
        do_start();
        run_basic();

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
